// File: rtl/seq_pkg.sv
// Shared types and constants for the 1-bit sequence link (transmitter and receiver side).
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } seq_tx_state_t;

    localparam logic SEQ_IDLE_LVL  = 1'b1;
    localparam logic SEQ_START_LVL = 1'b0;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seq_parity.sv
// Even-parity generator: output makes the total count of ones (data + parity) even.
module seq_parity #(
    parameter int DATA_W = 3
) (
    input  logic [DATA_W-1:0] data,
    output logic              parity
);

    assign parity = ^data;

endmodule

// File: rtl/seq_tx.sv
// Serial frame transmitter: start bit, data MSB-first, optional even parity, stop bits.
// Every output is a flop loaded from the next-state decode, so nothing on in_* reaches ser_o combinationally.
module seq_tx
    import seq_pkg::*;
#(
    parameter int DATA_W    = 3,
    parameter int PARITY_EN = 1,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              ser_o,
    output logic              busy,
    output logic [2:0]        bit_idx,
    output logic              done
);

    localparam int               CNT_W     = $clog2(max_int(DATA_W, STOP_BITS) + 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

    seq_tx_state_t     state_q, state_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [DATA_W-1:0] shreg_q, shreg_n;
    logic              par_q, par_n;
    logic              par_word;
    logic              accept;
    logic              ser_n, busy_n, done_n, ready_n;
    logic [2:0]        idx_n;

    // in_ready is high only in IDLE and the final STOP cycle, so accept always means "load a new frame".
    assign accept = in_valid & in_ready;

    seq_parity #(.DATA_W(DATA_W)) u_parity (
        .data   (in_data),
        .parity (par_word)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_n = state_q;
        shreg_n = shreg_q;
        par_n   = par_q;

        if (accept) begin
            shreg_n = in_data;
            par_n   = par_word;
        end

        unique case (state_q)
            IDLE:   if (accept) state_n = START;
            START:  state_n = DATA;
            DATA: begin
                if (cnt_q == DATA_LAST) state_n = (PARITY_EN != 0) ? PARITY : STOP;
                else                    shreg_n = shreg_q << 1;
            end
            PARITY: state_n = STOP;
            STOP:   if (cnt_q == STOP_LAST) state_n = accept ? START : IDLE;
            default: state_n = IDLE;
        endcase

        if (state_n == state_q && (state_q == DATA || state_q == STOP)) cnt_n = cnt_q + CNT_W'(1);
        else                                                            cnt_n = '0;

        ser_n = SEQ_IDLE_LVL;
        idx_n = '0;
        unique case (state_n)
            START:  ser_n = SEQ_START_LVL;
            DATA: begin
                ser_n = shreg_n[DATA_W-1];
                idx_n = 3'(DATA_W - 1 - int'(cnt_n));
            end
            PARITY: ser_n = par_n;
            default: ser_n = SEQ_IDLE_LVL;
        endcase

        busy_n  = (state_n != IDLE);
        done_n  = (state_n == STOP) && (cnt_n == STOP_LAST);
        ready_n = (state_n == IDLE) || done_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ser_o    <= SEQ_IDLE_LVL;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            bit_idx  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            ser_o    <= ser_n;
            in_ready <= ready_n;
            busy     <= busy_n;
            done     <= done_n;
            bit_idx  <= idx_n;
        end
    end

    // NOTE: the shift register and parity flop carry no reset; they are always loaded before use.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_n;
        par_q   <= par_n;
    end

endmodule

// File: tb/tb_seq_tx.sv
// Self-checking bench for seq_tx: default config (3/1/1) plus a 3-bit, no-parity, 2-stop instance.
module tb_seq_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       va, vb;
    logic [2:0] da, db;
    logic       ready_a, ser_a, busy_a, done_a;
    logic       ready_b, ser_b, busy_b, done_b;
    logic [2:0] idx_a, idx_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_tx dut_a (
        .clk(clk), .rst(rst), .in_valid(va), .in_data(da), .in_ready(ready_a),
        .ser_o(ser_a), .busy(busy_a), .bit_idx(idx_a), .done(done_a)
    );

    seq_tx #(.DATA_W(3), .PARITY_EN(0), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(vb), .in_data(db), .in_ready(ready_b),
        .ser_o(ser_b), .busy(busy_b), .bit_idx(idx_b), .done(done_b)
    );

    // Reference model: each accepted word becomes a list of line symbols; the line shows one per cycle.
    typedef struct {
        logic       b;
        logic [2:0] idx;
    } sym_t;

    sym_t       q[2][$];
    logic       e_ser[2], e_busy[2], e_done[2], e_ready[2];
    logic [2:0] e_idx[2];

    task automatic model_step(input int w, input logic r, input logic v, input logic [2:0] d);
        sym_t s;
        int   pe = (w == 0) ? 1 : 0;
        int   sb = (w == 0) ? 1 : 2;
        if (r) begin
            q[w].delete();
            e_ser[w] = 1'b1; e_busy[w] = 1'b0; e_done[w] = 1'b0; e_ready[w] = 1'b1; e_idx[w] = 3'd0;
            return;
        end
        if (v && q[w].size() == 0) begin
            q[w].push_back('{b: 1'b0, idx: 3'd0});
            for (int k = 2; k >= 0; k--) q[w].push_back('{b: d[k], idx: 3'(k)});
            if (pe != 0) q[w].push_back('{b: 1'($countones(d) % 2), idx: 3'd0});
            for (int k = 0; k < sb; k++) q[w].push_back('{b: 1'b1, idx: 3'd0});
        end
        if (q[w].size() > 0) begin
            s = q[w].pop_front();
            e_ser[w] = s.b; e_idx[w] = s.idx; e_busy[w] = 1'b1;
            e_done[w] = (q[w].size() == 0);
            e_ready[w] = e_done[w];
        end else begin
            e_ser[w] = 1'b1; e_busy[w] = 1'b0; e_done[w] = 1'b0; e_ready[w] = 1'b1; e_idx[w] = 3'd0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, rst, va, da);
        model_step(1, rst, vb, db);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (5) begin
            tick();
            total++;
            if ({ser_a, ready_a, busy_a, done_a, idx_a} !== 7'b1100_000) begin
                bad++;
                $display("FAIL reset_idle_a: got ser/rdy/busy/done/idx=%b want 1100000", {ser_a, ready_a, busy_a, done_a, idx_a});
            end
            total++;
            if ({ser_b, ready_b, busy_b, done_b, idx_b} !== 7'b1100_000) begin
                bad++;
                $display("FAIL reset_idle_b: got ser/rdy/busy/done/idx=%b want 1100000", {ser_b, ready_b, busy_b, done_b, idx_b});
            end
        end
    endtask

    task automatic test_frame_101();
        logic [5:0] seq = 6'b010101;
        logic [2:0] idx_exp[6] = '{3'd0, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0};
        va = 1'b1; da = 3'b101;
        for (int i = 0; i < 6; i++) begin
            tick();
            va = 1'b0;
            total++;
            if (ser_a !== seq[5-i] || done_a !== (i == 5) || busy_a !== 1'b1 || idx_a !== idx_exp[i]) begin
                bad++;
                $display("FAIL frame_101 cyc%0d: got ser=%b done=%b busy=%b idx=%0d want ser=%b done=%b busy=1 idx=%0d",
                         i, ser_a, done_a, busy_a, idx_a, seq[5-i], (i == 5), idx_exp[i]);
            end
        end
        tick();
        total++;
        if (ser_a !== 1'b1 || busy_a !== 1'b0) begin
            bad++;
            $display("FAIL frame_101_idle: got ser=%b busy=%b want ser=1 busy=0", ser_a, busy_a);
        end
    endtask

    task automatic test_sweep();
        logic bits[6];
        logic [2:0] word;
        for (int w = 0; w < 8; w++) begin
            va = 1'b1; da = 3'(w);
            for (int i = 0; i < 6; i++) begin
                tick();
                va = 1'b0;
                bits[i] = ser_a;
                total++;
                if (done_a !== (i == 5)) begin
                    bad++;
                    $display("FAIL sweep_len w=%0d cyc%0d: got done=%b want %b", w, i, done_a, (i == 5));
                end
            end
            word = {bits[1], bits[2], bits[3]};
            total++;
            if (bits[0] !== 1'b0 || bits[5] !== 1'b1 || word !== 3'(w)) begin
                bad++;
                $display("FAIL sweep_decode w=%0d: got start=%b word=%b stop=%b want start=0 word=%b stop=1",
                         w, bits[0], word, bits[5], 3'(w));
            end
            total++;
            if (bits[4] !== 1'($countones(3'(w)) % 2)) begin
                bad++;
                $display("FAIL sweep_parity w=%0d: got %b want %b", w, bits[4], 1'($countones(3'(w)) % 2));
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] seq = 12'b011111_000001;
        va = 1'b1; da = 3'b111;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i == 0) da = 3'b000;
            if (i == 6) va = 1'b0;
            total++;
            if (ser_a !== seq[11-i] || done_a !== (i == 5 || i == 11) || busy_a !== 1'b1) begin
                bad++;
                $display("FAIL back_to_back cyc%0d: got ser=%b done=%b busy=%b want ser=%b done=%b busy=1",
                         i, ser_a, done_a, busy_a, seq[11-i], (i == 5 || i == 11));
            end
        end
        tick();
        total++;
        if (busy_a !== 1'b0 || ser_a !== 1'b1) begin
            bad++;
            $display("FAIL back_to_back_idle: got busy=%b ser=%b want busy=0 ser=1", busy_a, ser_a);
        end
    endtask

    task automatic test_ignore_busy();
        logic [5:0] seq = 6'b011001;
        va = 1'b1; da = 3'b110;
        for (int i = 0; i < 6; i++) begin
            tick();
            va = 1'b0;
            if (i == 1) begin va = 1'b1; da = 3'b010; end
            total++;
            if (ser_a !== seq[5-i]) begin
                bad++;
                $display("FAIL ignore_busy cyc%0d: got ser=%b want %b", i, ser_a, seq[5-i]);
            end
        end
        repeat (2) begin
            tick();
            total++;
            if (busy_a !== 1'b0 || ser_a !== 1'b1) begin
                bad++;
                $display("FAIL ignore_busy_idle: got busy=%b ser=%b want busy=0 ser=1", busy_a, ser_a);
            end
        end
    endtask

    task automatic test_reset_mid();
        va = 1'b1; da = 3'b101;
        tick();
        va = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({ser_a, busy_a, done_a, ready_a} !== 4'b1001) begin
            bad++;
            $display("FAIL reset_mid: got ser/busy/done/rdy=%b want 1001", {ser_a, busy_a, done_a, ready_a});
        end
        repeat (6) begin
            tick();
            total++;
            if (done_a !== 1'b0 || ser_a !== 1'b1) begin
                bad++;
                $display("FAIL reset_mid_after: got done=%b ser=%b want done=0 ser=1", done_a, ser_a);
            end
        end
    endtask

    task automatic test_param_b();
        logic [5:0] seq = 6'b001111;
        vb = 1'b1; db = 3'b011;
        for (int i = 0; i < 6; i++) begin
            tick();
            vb = 1'b0;
            total++;
            if (ser_b !== seq[5-i] || done_b !== (i == 5) || ready_b !== (i == 5)) begin
                bad++;
                $display("FAIL param_b cyc%0d: got ser=%b done=%b rdy=%b want ser=%b done=%b rdy=%b",
                         i, ser_b, done_b, ready_b, seq[5-i], (i == 5), (i == 5));
            end
        end
        tick();
        total++;
        if (busy_b !== 1'b0 || ser_b !== 1'b1) begin
            bad++;
            $display("FAIL param_b_idle: got busy=%b ser=%b want busy=0 ser=1", busy_b, ser_b);
        end
    endtask

    task automatic test_random();
        logic       o_ser[2], o_busy[2], o_done[2], o_ready[2];
        logic [2:0] o_idx[2];
        for (int c = 0; c < 600; c++) begin
            va  = 1'($urandom_range(0, 1));
            vb  = 1'($urandom_range(0, 1));
            da  = 3'($urandom);
            db  = 3'($urandom);
            rst = ($urandom_range(0, 59) == 0);
            tick();
            o_ser   = '{ser_a, ser_b};
            o_busy  = '{busy_a, busy_b};
            o_done  = '{done_a, done_b};
            o_ready = '{ready_a, ready_b};
            o_idx   = '{idx_a, idx_b};
            for (int w = 0; w < 2; w++) begin
                total++;
                if (o_ser[w] !== e_ser[w] || o_busy[w] !== e_busy[w] || o_done[w] !== e_done[w] ||
                    o_ready[w] !== e_ready[w] || o_idx[w] !== e_idx[w]) begin
                    bad++;
                    $display("FAIL random dut%0d cyc%0d: got ser=%b busy=%b done=%b rdy=%b idx=%0d want ser=%b busy=%b done=%b rdy=%b idx=%0d",
                             w, c, o_ser[w], o_busy[w], o_done[w], o_ready[w], o_idx[w],
                             e_ser[w], e_busy[w], e_done[w], e_ready[w], e_idx[w]);
                end
            end
        end
        va = 1'b0; vb = 1'b0; rst = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        rst = 1'b1; va = 1'b0; vb = 1'b0; da = '0; db = '0;
        test_reset();
        test_frame_101();
        test_sweep();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
        test_param_b();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
